// File: rtl/fetch_iq_unit.sv
// fetch_iq_unit: builds 32-bit instructions from a byte-wide memory port, caches
// them in a direct-mapped I-cache and hands them to decode through a small queue.
module fetch_iq_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       IDX_W      = 6,
  parameter int unsigned       IQ_DEPTH_W = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              change_pc,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              icache_inv,
  input  logic              io_stall,
  input  logic              mem_rdy,
  input  logic [7:0]        mem_byte,
  output logic [ADDR_W-1:0] req_addr,
  output logic              out_valid,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);

  localparam int unsigned LINES  = 2 ** IDX_W;
  localparam int unsigned DEPTH  = 2 ** IQ_DEPTH_W;
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - 2;
  localparam int unsigned CNT_W  = IQ_DEPTH_W + 1;
  localparam int unsigned INST_W = 32;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } iq_entry_t;

  // fetch state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [23:0]       collect_q, collect_d;
  logic [ADDR_W-1:0] req_d;

  // cache arrays
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [INST_W-1:0] data_mem [LINES];

  // instruction queue
  iq_entry_t             iq_mem [DEPTH];
  logic [IQ_DEPTH_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0]      count_q;

  logic [IDX_W-1:0]  line_idx;
  logic [TAG_W-1:0]  line_tag;
  logic              hit_c;
  logic              deq_c;
  logic              space_c;
  logic              flush_c;
  logic              inv_c;
  logic              pop_c;
  logic              enq_c;
  logic              fill_c;
  logic [INST_W-1:0] enq_inst;
  iq_entry_t         enq_entry;

  assign line_idx  = pc_q[IDX_W+1:2];
  assign line_tag  = pc_q[ADDR_W-1:IDX_W+2];
  assign hit_c     = valid_q[line_idx] && (tag_mem[line_idx] == line_tag);

  assign out_valid = (count_q != '0);
  assign out_inst  = iq_mem[head_q].inst;
  assign out_pc    = iq_mem[head_q].pc;

  assign deq_c     = out_valid && out_ready;
  assign space_c   = (count_q < CNT_W'(DEPTH)) || deq_c;
  assign flush_c   = rdy_in && change_pc;
  assign inv_c     = rdy_in && icache_inv;
  assign pop_c     = rdy_in && !change_pc && deq_c;
  assign enq_entry = '{inst: enq_inst, pc: pc_q};

  // Next-state: redirect, then queue-full hold, then cache hit, then byte path.
  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    collect_d = collect_q;
    req_d     = req_addr;
    enq_c     = 1'b0;
    fill_c    = 1'b0;
    enq_inst  = '0;

    if (rdy_in) begin
      if (change_pc) begin
        pc_d   = next_pc & ~ADDR_W'(3);
        req_d  = next_pc & ~ADDR_W'(3);
        cnt_d  = '0;
        pend_d = 1'b0;
      end else if (!space_c) begin
        // byte in flight is dropped and re-requested once space frees up
        req_d  = pc_q + ADDR_W'(cnt_q);
        pend_d = 1'b0;
      end else if (cnt_q == 2'd0 && hit_c) begin
        enq_c    = 1'b1;
        enq_inst = data_mem[line_idx];
        pc_d     = pc_q + ADDR_W'(4);
        req_d    = pc_q + ADDR_W'(4);
        pend_d   = 1'b0;
      end else begin
        pend_d = mem_rdy;
        if (mem_rdy) begin
          req_d = req_addr + ADDR_W'(1);
        end
        if (pend_q && !io_stall) begin
          if (cnt_q == 2'd3) begin
            enq_c    = 1'b1;
            fill_c   = 1'b1;
            enq_inst = {mem_byte, collect_q};
            pc_d     = pc_q + ADDR_W'(4);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
              2'd0:    collect_d[7:0]   = mem_byte;
              2'd1:    collect_d[15:8]  = mem_byte;
              default: collect_d[23:16] = mem_byte;
            endcase
          end
        end
        // IO write borrows the port: rewind to the first byte not yet collected
        if (io_stall) begin
          req_d  = pc_q + ADDR_W'(cnt_q);
          pend_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc_q      <= RESET_PC;
      req_addr  <= RESET_PC;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      collect_q <= '0;
    end else begin
      pc_q      <= pc_d;
      req_addr  <= req_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      collect_q <= collect_d;
    end
  end

  // Valid bits: invalidation beats a same-cycle refill.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (inv_c) begin
      valid_q <= '0;
    end else if (fill_c) begin
      valid_q[line_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_c && !inv_c) begin
      tag_mem[line_idx]  <= line_tag;
      data_mem[line_idx] <= enq_inst;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      iq_mem  <= '{default: '0};
    end else if (flush_c) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_c) begin
        iq_mem[tail_q] <= enq_entry;
        tail_q         <= tail_q + IQ_DEPTH_W'(1);
      end
      if (pop_c) begin
        head_q <= head_q + IQ_DEPTH_W'(1);
      end
      count_q <= count_q + CNT_W'(enq_c) - CNT_W'(pop_c);
    end
  end

endmodule
